// File: rtl/hack_defs_pkg.sv
// Shared Hack memory-map constants, responder state encoding and region codes.
// Used by the responder, its address decoder and the CPU-side benches.
package hack_defs;
    localparam int SCREEN_BASE = 16384;
    localparam int KBD_ADDR    = 24576;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_KBD, REG_ILL} region_t;
endpackage

// File: rtl/hack_addr_decode.sv
// Combinational Hack address-map decode: region, illegal-access flag and SRAM word address.
module hack_addr_decode
    import hack_defs::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              fetch,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    output region_t           region,
    output logic              err,
    output logic [13:0]       ram_addr
);
    localparam logic [ADDR_W-1:0] SCREEN_A = ADDR_W'(SCREEN_BASE);
    localparam logic [ADDR_W-1:0] KBD_A    = ADDR_W'(KBD_ADDR);

    always_comb begin
        region   = REG_ILL;
        err      = 1'b1;
        ram_addr = addr[13:0];
        if (fetch) begin
            if (!we) begin
                region = REG_ROM;
                err    = 1'b0;
            end
        end else if (addr < KBD_A) begin
            region = REG_RAM;
            err    = 1'b0;
            // Screen words live in the upper half of the shared SRAM.
            if (addr >= SCREEN_A) ram_addr = {1'b1, addr[12:0]};
        end else if (addr == KBD_A) begin
            region = REG_KBD;
            err    = we;
        end
    end
endmodule

// File: rtl/hack_mem_responder.sv
// Memory-side responder for the multi-cycle Hack CPU: one request at a time over req/ack,
// routed to sync ROM, shared sync SRAM (RAM + screen) or the synchronised keyboard register.
module hack_mem_responder
    import hack_defs::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_fetch,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [13:0]       ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] kbd
);
    state_t            state, state_nxt;
    region_t           dec_region, region_q;
    logic              dec_err, err_q, we_q;
    logic [13:0]       dec_ram_addr, ram_addr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, kbd_meta, kbd_sync, resp_data;
    logic [3:0]        wait_cnt;

    hack_addr_decode #(.ADDR_W(ADDR_W)) u_dec (
        .fetch    (cpu_fetch),
        .we       (cpu_we),
        .addr     (cpu_addr),
        .region   (dec_region),
        .err      (dec_err),
        .ram_addr (dec_ram_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kbd_meta <= '0;
            kbd_sync <= '0;
        end else begin
            kbd_meta <= kbd;
            kbd_sync <= kbd_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            region_q   <= REG_ILL;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nxt;
            // Request fields are captured once; later input changes are ignored.
            if (state == ST_IDLE && cpu_req) begin
                region_q   <= dec_region;
                err_q      <= dec_err;
                we_q       <= cpu_we;
                addr_q     <= cpu_addr;
                ram_addr_q <= dec_ram_addr;
                wdata_q    <= cpu_wdata;
            end
            if (state == ST_ACCESS) wait_cnt <= 4'(WAIT_CYCLES - 1);
            else if (state == ST_WAIT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            if (state == ST_RESP) rdata_q <= resp_data;
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = rdata_q;
        rom_en    = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        resp_data = '0;
        rom_addr  = addr_q;
        ram_addr  = ram_addr_q;
        ram_wdata = wdata_q;

        // Writes and illegal accesses always return zero.
        case (region_q)
            REG_ROM: resp_data = rom_rdata;
            REG_RAM: if (!we_q) resp_data = ram_rdata;
            REG_KBD: if (!we_q) resp_data = kbd_sync;
            default: resp_data = '0;
        endcase

        case (state)
            ST_IDLE: if (cpu_req) state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                rom_en    = (region_q == REG_ROM);
                ram_en    = (region_q == REG_RAM);
                ram_we    = (region_q == REG_RAM) && we_q;
                state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_RESP;
            ST_RESP: begin
                cpu_ack   = 1'b1;
                cpu_err   = err_q;
                cpu_rdata = resp_data;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_hack_mem_responder.sv
// Bench for hack_mem_responder: directed scenarios plus random accesses against a map-level model.
module tb_hack_mem_responder;
    logic        clk = 0;
    logic        reset = 1;
    logic        req0 = 0, req3 = 0;
    logic        fetch = 0, we = 0;
    logic [14:0] addr = '0;
    logic [15:0] wdata = '0, kbd = '0;

    logic        ack0, err0, rom_en0, ram_en0, ram_we0;
    logic [15:0] rdata0, rom_rdata0, ram_wdata0, ram_rdata0;
    logic [14:0] rom_addr0;
    logic [13:0] ram_addr0;

    logic        ack3, err3, rom_en3, ram_en3, ram_we3;
    logic [15:0] rdata3, rom_rdata3, ram_wdata3;
    logic [15:0] ram_rdata3 = '0;
    logic [14:0] rom_addr3;
    logic [13:0] ram_addr3;

    bit   [15:0] ram0 [0:16383];
    bit   [15:0] ref_mem [int];
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    hack_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .cpu_req(req0), .cpu_fetch(fetch), .cpu_we(we),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_ack(ack0), .cpu_rdata(rdata0), .cpu_err(err0),
        .rom_en(rom_en0), .rom_addr(rom_addr0), .rom_rdata(rom_rdata0),
        .ram_en(ram_en0), .ram_we(ram_we0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
        .ram_rdata(ram_rdata0), .kbd(kbd));

    hack_mem_responder #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .cpu_req(req3), .cpu_fetch(fetch), .cpu_we(we),
        .cpu_addr(addr), .cpu_wdata(wdata), .cpu_ack(ack3), .cpu_rdata(rdata3), .cpu_err(err3),
        .rom_en(rom_en3), .rom_addr(rom_addr3), .rom_rdata(rom_rdata3),
        .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
        .ram_rdata(ram_rdata3), .kbd(kbd));

    function automatic logic [15:0] rom_f(input logic [14:0] a);
        return {~a[0], a} ^ 16'hC3A5;
    endfunction

    // Synchronous ROM/SRAM models; read data holds until the next enabled read.
    always @(posedge clk) begin
        if (rom_en0) rom_rdata0 <= rom_f(rom_addr0);
        if (rom_en3) rom_rdata3 <= rom_f(rom_addr3);
        if (ram_en0) begin
            if (ram_we0) ram0[ram_addr0] <= ram_wdata0;
            else ram_rdata0 <= ram0[ram_addr0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction on the zero-wait instance, checked against the memory-map rules.
    task automatic op0(input string tag, input logic f, input logic w,
                       input logic [14:0] a, input logic [15:0] d);
        logic [15:0] exp_rd = '0;
        logic        exp_err = 1'b0;
        int          exp_rom = 0, exp_ram = 0, exp_we = 0, idx = 0;
        int          cyc = 0, rom_c = 0, ram_c = 0, we_c = 0;
        logic [13:0] seen_idx = '0;
        if (f) begin
            exp_err = w;
            if (!w) begin exp_rom = 1; exp_rd = rom_f(a); end
        end else if (a < 24576) begin
            idx     = (a < 16384) ? int'(a) : 8192 + (int'(a) - 16384);
            exp_ram = 1;
            if (w) exp_we = 1;
            else exp_rd = ref_mem.exists(idx) ? ref_mem[idx] : 16'h0;
        end else if (a == 24576) begin
            exp_err = w;
            if (!w) exp_rd = kbd;
        end else exp_err = 1'b1;

        fetch = f; we = w; addr = a; wdata = d; req0 = 1;
        while (cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                addr = 15'($urandom); wdata = 16'($urandom); we = ~w; fetch = ~f;
            end
            if (rom_en0) rom_c++;
            if (ram_en0) begin ram_c++; seen_idx = ram_addr0; end
            if (ram_we0) we_c++;
            if (ack0) break;
        end
        req0 = 0;
        if (exp_we == 1) ref_mem[idx] = d;
        chk({tag, ".lat"},   cyc, 2);
        chk({tag, ".rdata"}, rdata0, exp_rd);
        chk({tag, ".err"},   err0, exp_err);
        chk({tag, ".rom"},   rom_c, exp_rom);
        chk({tag, ".ram"},   ram_c, exp_ram);
        chk({tag, ".we"},    we_c, exp_we);
        if (exp_ram == 1) chk({tag, ".ridx"}, seen_idx, idx);
        tick();
        chk({tag, ".noack"}, ack0, 1'b0);
        chk({tag, ".hold"},  rdata0, exp_rd);
    endtask

    initial begin
        int acc_ack = 0, acc_str = 0, t1 = 0, t2 = 0, cyc = 0;
        logic [15:0] rd1 = '0, rd2 = '0;
        logic        e1 = 1'b0, e2 = 1'b0;

        // Reset held while a request is pending.
        fetch = 0; we = 0; addr = 15'd5; req0 = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack0 || ack3) acc_ack++;
            if (rom_en0 || ram_en0 || ram_we0 || rom_en3 || ram_en3 || ram_we3) acc_str++;
        end
        chk("rst.ack", acc_ack, 0);
        chk("rst.strobe", acc_str, 0);
        chk("rst.rdata", rdata0, 16'h0);
        chk("rst.err", err0, 1'b0);
        reset = 0;
        op0("rst_rel", 0, 0, 15'd5, 16'h0);

        op0("ram_wr", 0, 1, 15'd5, 16'h1234);
        op0("ram_rd", 0, 0, 15'd5, 16'h0);
        op0("scr_wr", 0, 1, 15'd16384, 16'hFFFF);
        op0("scr_rd", 0, 0, 15'd16384, 16'h0);

        kbd = 16'h0041;
        tick(); tick(); tick();
        op0("kbd_rd", 0, 0, 15'd24576, 16'h0);
        op0("kbd_wr", 0, 1, 15'd24576, 16'h5555);
        op0("ill_rd", 0, 0, 15'd24577, 16'h0);
        op0("ill_fwe", 1, 1, 15'd3, 16'h7777);
        op0("rom_top", 1, 0, 15'h7FFF, 16'h0);

        // Reset during the write strobe: strobes drop at once, no write lands.
        fetch = 0; we = 1; addr = 15'd7; wdata = 16'hBEEF; req0 = 1;
        tick();
        chk("abort.we_pre", ram_we0, 1'b1);
        reset = 1;
        #1;
        chk("abort.we", ram_we0, 1'b0);
        chk("abort.en", ram_en0, 1'b0);
        req0 = 0;
        acc_ack = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (ack0) acc_ack++; end
        chk("abort.ack", acc_ack, 0);
        reset = 0;
        tick();
        op0("abort_rd", 0, 0, 15'd7, 16'h0);

        // Back-to-back fetches on the three-wait-state instance.
        fetch = 1; we = 0; addr = 15'd0; req3 = 1;
        while (cyc < 30) begin
            tick();
            cyc++;
            if (ack3) begin
                if (t1 == 0) begin t1 = cyc; rd1 = rdata3; e1 = err3; addr = 15'd1; end
                else begin t2 = cyc; rd2 = rdata3; e2 = err3; break; end
            end
        end
        req3 = 0;
        chk("w3.t1", t1, 5);
        chk("w3.t2", t2, 11);
        chk("w3.rd1", rd1, rom_f(15'd0));
        chk("w3.rd2", rd2, rom_f(15'd1));
        chk("w3.err", {e1, e2}, 2'b00);
        tick();

        // Random mix over every region.
        for (int n = 0; n < 40; n++) begin
            logic [14:0] a;
            logic        f, w;
            int          k = int'($urandom_range(0, 5));
            w = 1'($urandom);
            f = 1'b0;
            case (k)
                0: begin f = 1; w = 0; a = 15'($urandom); end
                1: begin f = 1; w = 1; a = 15'($urandom); end
                2: a = 15'($urandom_range(0, 15));
                3: a = 15'($urandom_range(16384, 16399));
                4: a = 15'd24576;
                default: a = 15'($urandom_range(24577, 32767));
            endcase
            if (k == 4) begin kbd = 16'($urandom); tick(); tick(); tick(); end
            op0($sformatf("rnd%0d", n), f, w, a, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
